// File: rtl/regfile_pkg.sv
// Shared parameters, types and helpers for the register-file storage stage.
package regfile_pkg;
    localparam int              DATA_W   = 16;
    localparam int              NUM_REGS = 10;
    localparam int              SP_IDX   = 9;
    localparam int              SP_STEP  = 2;
    localparam logic [DATA_W-1:0] SP_RESET = 16'hFFFE;

    typedef logic [3:0]        reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

    function automatic logic is_legal_addr(input reg_addr_t a);
        return (a < reg_addr_t'(NUM_REGS));
    endfunction
endpackage

// File: rtl/regfile_sp_counter.sv
// Stack-pointer register: load, +/-SP_STEP, sticky carry/borrow flags.
// With REGFILE_WRITE_BYPASS_EN the next-state value is exported for write-through.
module regfile_sp_counter
    import regfile_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  data_t i_load_data,
    input  logic  i_inc,
    input  logic  i_dec,
    input  logic  i_clr,
    output data_t o_sp,
`ifdef REGFILE_WRITE_BYPASS_EN
    output data_t o_sp_next,
`endif
    output logic  o_ovf,
    output logic  o_unf
);
    data_t             r_sp;
    logic              r_ovf;
    logic              r_unf;
    logic [DATA_W:0]   w_sum;
    data_t             w_diff;
    data_t             w_next;
    logic              w_do_inc;
    logic              w_do_dec;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    // A load owns the cycle; simultaneous inc and dec cancel out.
    assign w_do_inc  = i_inc & ~i_dec & ~i_load;
    assign w_do_dec  = i_dec & ~i_inc & ~i_load;
    assign w_sum     = {1'b0, r_sp} + (DATA_W+1)'(SP_STEP);
    assign w_diff    = r_sp - DATA_W'(SP_STEP);
    assign w_ovf_evt = w_do_inc & w_sum[DATA_W];
    assign w_unf_evt = w_do_dec & (r_sp < DATA_W'(SP_STEP));

    always_comb begin
        w_next = r_sp;
        if (i_load)        w_next = i_load_data;
        else if (w_do_inc) w_next = w_sum[DATA_W-1:0];
        else if (w_do_dec) w_next = w_diff;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= SP_RESET;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp <= w_next;
            if (w_ovf_evt)  r_ovf <= 1'b1;
            else if (i_clr) r_ovf <= 1'b0;
            if (w_unf_evt)  r_unf <= 1'b1;
            else if (i_clr) r_unf <= 1'b0;
        end
    end

    assign o_sp  = r_sp;
    assign o_ovf = r_ovf;
    assign o_unf = r_unf;
`ifdef REGFILE_WRITE_BYPASS_EN
    assign o_sp_next = w_next;
`endif
endmodule

// File: rtl/register_file_v2_bank.sv
// Ten-register storage bank feeding the read mux; R[SP_IDX] is the stack pointer.
// Optional write-through outputs under REGFILE_WRITE_BYPASS_EN.
module register_file_v2_bank
    import regfile_pkg::*;
(
    input  logic      CLK,
    input  logic      Reset,
    input  logic      WrEn,
    input  reg_addr_t WrAddr,
    input  data_t     WrData,
    input  logic      SpInc,
    input  logic      SpDec,
    input  logic      ClrFlags,
    output data_t     R0,
    output data_t     R1,
    output data_t     R2,
    output data_t     R3,
    output data_t     R4,
    output data_t     R5,
    output data_t     R6,
    output data_t     R7,
    output data_t     R8,
    output data_t     R9,
    output logic      SpOverflow,
    output logic      SpUnderflow,
    output logic      WrErr
);
    logic  w_wr_legal;
    logic  w_sp_load;
    data_t w_sp;
    data_t w_q  [NUM_REGS];
    data_t w_rd [NUM_REGS];
    logic  r_wr_err;
`ifdef REGFILE_WRITE_BYPASS_EN
    data_t w_sp_next;
`endif

    assign w_wr_legal = WrEn & is_legal_addr(WrAddr);
    assign w_sp_load  = w_wr_legal & (WrAddr == reg_addr_t'(SP_IDX));

    regfile_sp_counter u_sp (
        .clk         (CLK),
        .rst         (Reset),
        .i_load      (w_sp_load),
        .i_load_data (WrData),
        .i_inc       (SpInc),
        .i_dec       (SpDec),
        .i_clr       (ClrFlags),
        .o_sp        (w_sp),
`ifdef REGFILE_WRITE_BYPASS_EN
        .o_sp_next   (w_sp_next),
`endif
        .o_ovf       (SpOverflow),
        .o_unf       (SpUnderflow)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == SP_IDX) begin : g_sp
            assign w_q[g] = w_sp;
`ifdef REGFILE_WRITE_BYPASS_EN
            assign w_rd[g] = w_sp_next;
`else
            assign w_rd[g] = w_q[g];
`endif
        end else begin : g_gp
            data_t r_q;
            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset)
                    r_q <= '0;
                else if (w_wr_legal && WrAddr == reg_addr_t'(g))
                    r_q <= WrData;
            end
            assign w_q[g] = r_q;
`ifdef REGFILE_WRITE_BYPASS_EN
            assign w_rd[g] = (w_wr_legal && WrAddr == reg_addr_t'(g)) ? WrData : r_q;
`else
            assign w_rd[g] = r_q;
`endif
        end
    end

    // Set beats clear so an error in the clearing cycle is not lost.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                    r_wr_err <= 1'b0;
        else if (WrEn && !w_wr_legal) r_wr_err <= 1'b1;
        else if (ClrFlags)            r_wr_err <= 1'b0;
    end

    assign WrErr = r_wr_err;
    assign R0 = w_rd[0];
    assign R1 = w_rd[1];
    assign R2 = w_rd[2];
    assign R3 = w_rd[3];
    assign R4 = w_rd[4];
    assign R5 = w_rd[5];
    assign R6 = w_rd[6];
    assign R7 = w_rd[7];
    assign R8 = w_rd[8];
    assign R9 = w_rd[9];
endmodule

// File: tb/tb_register_file_v2_bank.sv
// Directed table-driven bench for register_file_v2_bank plus reset/bypass sequences.
module tb_register_file_v2_bank;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [15:0] WrData;
    logic        SpInc;
    logic        SpDec;
    logic        ClrFlags;
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9;
    logic        SpOverflow;
    logic        SpUnderflow;
    logic        WrErr;
    logic [15:0] rr [10];

    int errors = 0;
    int checks = 0;

    register_file_v2_bank dut (
        .CLK(CLK), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .SpInc(SpInc), .SpDec(SpDec), .ClrFlags(ClrFlags),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4),
        .R5(R5), .R6(R6), .R7(R7), .R8(R8), .R9(R9),
        .SpOverflow(SpOverflow), .SpUnderflow(SpUnderflow), .WrErr(WrErr)
    );

    always #5 CLK = ~CLK;

    assign rr[0] = R0; assign rr[1] = R1; assign rr[2] = R2; assign rr[3] = R3;
    assign rr[4] = R4; assign rr[5] = R5; assign rr[6] = R6; assign rr[7] = R7;
    assign rr[8] = R8; assign rr[9] = R9;

    typedef struct {
        logic        wr_en;
        logic [3:0]  addr;
        logic [15:0] data;
        logic        inc;
        logic        dec;
        logic        clr;
        int          ia;
        logic [15:0] va;
        int          ib;
        logic [15:0] vb;
        logic        ovf;
        logic        unf;
        logic        err;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        WrEn = 0; WrAddr = 0; WrData = 0; SpInc = 0; SpDec = 0; ClrFlags = 0;
    endtask

    task automatic add(input logic we, input logic [3:0] a, input logic [15:0] d,
                       input logic inc, input logic dec, input logic clr,
                       input int ia, input logic [15:0] va, input int ib, input logic [15:0] vb,
                       input logic ovf, input logic unf, input logic err);
        vec_t v;
        v.wr_en = we; v.addr = a; v.data = d; v.inc = inc; v.dec = dec; v.clr = clr;
        v.ia = ia; v.va = va; v.ib = ib; v.vb = vb; v.ovf = ovf; v.unf = unf; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        idle();
        Reset = 1'b1;

        //      we a   data     inc dec clr  ia va        ib va       ovf unf err
        add(1, 5,  16'hBEEF, 0, 0, 0,   5, 16'hBEEF,  9, 16'hFFFE, 0, 0, 0);
        add(0, 0,  16'h0000, 0, 0, 0,   4, 16'h0000,  5, 16'hBEEF, 0, 0, 0);
        add(1, 12, 16'h7777, 0, 0, 0,   5, 16'hBEEF,  2, 16'h0000, 0, 0, 1);
        add(0, 0,  16'h0000, 0, 0, 0,   9, 16'hFFFE,  5, 16'hBEEF, 0, 0, 1);
        add(0, 0,  16'h0000, 0, 0, 1,   9, 16'hFFFE,  5, 16'hBEEF, 0, 0, 0);
        add(0, 0,  16'h0000, 1, 0, 0,   9, 16'h0000,  5, 16'hBEEF, 1, 0, 0);
        add(0, 0,  16'h0000, 0, 1, 0,   9, 16'hFFFE,  0, 16'h0000, 1, 1, 0);
        add(0, 0,  16'h0000, 0, 0, 1,   9, 16'hFFFE,  5, 16'hBEEF, 0, 0, 0);
        add(1, 9,  16'h0100, 0, 1, 0,   9, 16'h0100,  5, 16'hBEEF, 0, 0, 0);
        add(0, 0,  16'h0000, 1, 1, 0,   9, 16'h0100,  0, 16'h0000, 0, 0, 0);
        add(1, 9,  16'h0010, 0, 0, 0,   9, 16'h0010,  2, 16'h0000, 0, 0, 0);
        add(1, 2,  16'h00AA, 0, 1, 0,   2, 16'h00AA,  9, 16'h000E, 0, 0, 0);
        add(1, 9,  16'hFFFF, 0, 0, 0,   9, 16'hFFFF,  2, 16'h00AA, 0, 0, 0);
        add(0, 0,  16'h0000, 1, 0, 1,   9, 16'h0001,  5, 16'hBEEF, 1, 0, 0);
        add(0, 0,  16'h0000, 0, 1, 0,   9, 16'hFFFF,  2, 16'h00AA, 1, 1, 0);
        add(1, 15, 16'h4321, 0, 0, 1,   9, 16'hFFFF,  3, 16'h0000, 0, 0, 1);
        add(1, 9,  16'h1234, 1, 0, 1,   9, 16'h1234,  5, 16'hBEEF, 0, 0, 0);
        add(1, 9,  16'h0000, 0, 1, 0,   9, 16'h0000,  2, 16'h00AA, 0, 0, 0);

        // Reset state, then a write to R3 that a mid-cycle reset must undo.
        #1;
        chk("rst_r9", R9, 16'hFFFE);
        chk("rst_r0", R0, 16'h0000);
        @(negedge CLK); Reset = 1'b0;
        @(negedge CLK); WrEn = 1; WrAddr = 3; WrData = 16'h1111;
        @(posedge CLK); #1 idle();
        #1 chk("pre_r3", R3, 16'h1111);
        @(negedge CLK); WrEn = 1; WrAddr = 3; WrData = 16'h1234; SpDec = 1;
        #2 Reset = 1'b1;
        #1;
        chk("midrst_r3", R3, 16'h0000);
        chk("midrst_r9", R9, 16'hFFFE);
        chk("midrst_flags", {13'b0, SpOverflow, SpUnderflow, WrErr}, 16'h0000);
        @(posedge CLK); #1;
        chk("hold_r3", R3, 16'h0000);
        @(negedge CLK); idle(); Reset = 1'b0;
        @(posedge CLK); #2;
        chk("rel_r3", R3, 16'h0000);
        chk("rel_r9", R9, 16'hFFFE);

        foreach (vecs[i]) begin
            @(negedge CLK);
            WrEn = vecs[i].wr_en; WrAddr = vecs[i].addr; WrData = vecs[i].data;
            SpInc = vecs[i].inc; SpDec = vecs[i].dec; ClrFlags = vecs[i].clr;
            @(posedge CLK); #1 idle();
            #1;
            chk($sformatf("v%0d_r%0d", i, vecs[i].ia), rr[vecs[i].ia], vecs[i].va);
            chk($sformatf("v%0d_r%0d", i, vecs[i].ib), rr[vecs[i].ib], vecs[i].vb);
            chk($sformatf("v%0d_ovf", i), {15'b0, SpOverflow}, {15'b0, vecs[i].ovf});
            chk($sformatf("v%0d_unf", i), {15'b0, SpUnderflow}, {15'b0, vecs[i].unf});
            chk($sformatf("v%0d_err", i), {15'b0, WrErr}, {15'b0, vecs[i].err});
        end

        // Write-through visibility of a pending write to R0 before the edge.
        @(negedge CLK); WrEn = 1; WrAddr = 0; WrData = 16'h5A5A;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("byp_r0_pre", R0, 16'h5A5A);
`else
        chk("byp_r0_pre", R0, 16'h0000);
`endif
        @(posedge CLK); #1 idle();
        #1 chk("byp_r0_post", R0, 16'h5A5A);
        chk("final_r5", R5, 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_file_v2_bank.md
Name: register_file_v2_bank

Overview:
Storage stage of the register file: ten 16-bit registers and a write port; the block directly upstream of the read-port mux.
- Drives the mux's ten data inputs (R0..R9 map to mux inputs A..J) straight from flops.
- Register SP_IDX is the stack pointer. It supports single-cycle push/pop increment and decrement with sticky wrap flags, which the accumulator core uses for call/return and stack ops.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 10, number of architectural registers; legal write addresses are 0..NUM_REGS-1.
- SP_IDX, 9, index of the stack-pointer register.
- SP_STEP, 2, byte step applied by SpInc/SpDec.
- SP_RESET, 16'hFFFE, stack-pointer value after reset.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- WrEn  input  1  write strobe.
- WrAddr  input  4  destination register index.
- WrData  input  DATA_W  write data.
- SpInc  input  1  add SP_STEP to SP (pop).
- SpDec  input  1  subtract SP_STEP from SP (push).
- ClrFlags  input  1  clear sticky flags.
- R0..R9  output  DATA_W each  current register contents, to read mux inputs A..J.
- SpOverflow  output  1  sticky: SP increment wrapped past 16'hFFFF.
- SpUnderflow  output  1  sticky: SP decrement wrapped below 0.
- WrErr  output  1  sticky: write attempted to an illegal address.

Behaviour:
- Reset (async, Reset=1): all registers 0 except R[SP_IDX]=SP_RESET; SpOverflow=SpUnderflow=WrErr=0. Holds while Reset is high; the release is sampled on the next CLK edge.
- Reset mid-operation: pending write, inc or dec is discarded; no partial update.
- Write: on a CLK edge with WrEn=1 and WrAddr<NUM_REGS, R[WrAddr]<=WrData. Visible on outputs the cycle after the edge (1-cycle write latency); reads are flop outputs with 0 added latency.
- Illegal address: WrEn=1 with WrAddr in 10..15 writes nothing and sets WrErr.
- SP ops:
  - SpInc=1, SpDec=0: SP<=SP+SP_STEP, modulo 2^16.
  - SpDec=1, SpInc=0: SP<=SP-SP_STEP, modulo 2^16.
  - SpInc=SpDec=1: SP unchanged, no flag change.
- Wrap detection:
  - Overflow when SP+SP_STEP>16'hFFFF (17-bit carry out); sets SpOverflow.
  - Underflow when SP<SP_STEP (borrow); sets SpUnderflow.
- Priority: WrEn targeting SP_IDX beats SpInc/SpDec. SP takes WrData, the inc/dec is dropped, and no wrap flag is set that cycle. A write to any other register proceeds in parallel with an SP inc/dec.
- Flags: sticky until ClrFlags=1 on a clock edge. If a set condition and ClrFlags occur in the same cycle, set wins and the flag stays 1.
- No other state; there is no handshake, and every request completes in the cycle it is presented.

Optional Feature:
REGFILE_WRITE_BYPASS_EN
- Defined: write-through. In the cycle WrEn=1 with a legal WrAddr, output R[WrAddr] shows WrData combinationally before the edge. The same applies to SP: WrData when written, otherwise the pending inc/dec result. Flop update is unchanged.
- Undefined: outputs are pure flop Q; new values appear the cycle after the edge.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, NUM_REGS, SP_IDX, SP_STEP, SP_RESET;
  - reg_addr_t (4-bit) and data_t (DATA_W-bit) typedefs;
  - function is_legal_addr.
- One sub-module, regfile_sp_counter, owns the SP register:
  - inputs: load, load data, inc, dec, clear-flags;
  - outputs: SP value and both sticky wrap flags.
- The remaining registers and WrErr stay in the top-level block.

Test Plan:
- Reset asserted mid-write (WrEn=1, WrAddr=3, WrData=16'h1234) -> R3=0, R9=16'hFFFE, all flags 0 immediately, and R3 still 0 after release.
- WrEn=1, WrAddr=5, WrData=16'hBEEF -> R5=16'hBEEF the next cycle, all other regs unchanged. WrAddr=12 -> no register changes, WrErr=1 until ClrFlags.
- SP=16'hFFFE, SpInc=1 -> SP=16'h0000, SpOverflow=1. Then SpDec=1 -> SP=16'hFFFE, SpUnderflow=1. ClrFlags=1 with no new wrap -> both flags 0.
- WrEn=1, WrAddr=9, WrData=16'h0100 with SpDec=1 -> SP=16'h0100 and no flag set. SpInc=SpDec=1 -> SP unchanged.
- WrEn=1, WrAddr=2, WrData=16'h00AA with SpDec=1 from SP=16'h0010 -> R2=16'h00AA, SP=16'h000E in the same cycle.
- With REGFILE_WRITE_BYPASS_EN: WrEn=1, WrAddr=0, WrData=16'h5A5A -> R0 reads 16'h5A5A before the edge. Without the macro, R0 reads the old value until after the edge.
